// File: rtl/dual_grant_pkg.sv
// dual_grant_pkg: shared types and helpers for the dual-channel arbiter.
// Request codes: 0 means no grant, codes 1..12 map to req[0]..req[11].
package dual_grant_pkg;

    localparam int NUM_REQ = 12;
    localparam int CODE_W  = 4;

    typedef logic [CODE_W-1:0] code_t;

    localparam code_t NO_GRANT = 4'd0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } chan_state_t;

    // Expand an owner code into a one-hot request mask (all zero for NO_GRANT)
    function automatic logic [NUM_REQ-1:0] code_to_onehot(input code_t code);
        logic [NUM_REQ-1:0] v;
        for (int i = 0; i < NUM_REQ; i++) begin
            v[i] = (code == code_t'(i + 1));
        end
        return v;
    endfunction

    // Convert a requester index (0..11) into its request code (1..12)
    function automatic code_t index_to_code(input logic [3:0] idx);
        return code_t'(idx + 4'd1);
    endfunction

endpackage

// File: rtl/dual_pick_12.sv
// dual_pick_12: combinational first/second priority picker over 12 requests.
// Default build: fixed priority, index 11 highest, index 0 lowest.
// With ROUND_ROBIN_EN defined, priority descends cyclically from the index
// just below i_ptr, so the index held in i_ptr is the lowest priority.
module dual_pick_12
    import dual_grant_pkg::*;
(
`ifdef ROUND_ROBIN_EN
    input  logic [3:0]         i_ptr,
`endif
    input  logic [NUM_REQ-1:0] i_vec,
    output code_t              o_first,
    output code_t              o_second
);

    // Walk the priority order and capture the first two set bits
    always_comb begin
        logic [3:0] w_idx;
        o_first  = NO_GRANT;
        o_second = NO_GRANT;
        w_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
`ifdef ROUND_ROBIN_EN
            if (k <= int'(i_ptr)) begin
                w_idx = 4'(int'(i_ptr) - k);
            end else begin
                w_idx = 4'(int'(i_ptr) + NUM_REQ - k);
            end
`else
            w_idx = 4'(NUM_REQ - k);
`endif
            if (i_vec[w_idx]) begin
                if (o_first == NO_GRANT) begin
                    o_first = index_to_code(w_idx);
                end else if (o_second == NO_GRANT) begin
                    o_second = index_to_code(w_idx);
                end
            end
        end
    end

endmodule

// File: rtl/dual_grant_arbiter.sv
// dual_grant_arbiter: shares channels A and B among 12 requesters.
// Each channel is an IDLE/BUSY FSM; grants are held until done, request drop,
// or the hold limit (MAX_HOLD, 0 = unlimited). Timed-out requesters are locked
// out until they drop their request. Optional macro ROUND_ROBIN_EN adds a
// rotating priority pointer; without it priority is fixed (req[11] highest).
module dual_grant_arbiter
    import dual_grant_pkg::*;
#(
    parameter int MAX_HOLD = 255,
    parameter int HOLD_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done_a,
    input  logic               done_b,
    output logic [CODE_W-1:0]  gnt_a_id,
    output logic [CODE_W-1:0]  gnt_b_id,
    output logic               gnt_a_valid,
    output logic               gnt_b_valid,
    output logic               timeout_a,
    output logic               timeout_b
);

    localparam bit                HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    chan_state_t        r_a_state, w_a_state;
    chan_state_t        r_b_state, w_b_state;
    code_t              r_a_id, w_a_id;
    code_t              r_b_id, w_b_id;
    logic [HOLD_W-1:0]  r_a_cnt, w_a_cnt;
    logic [HOLD_W-1:0]  r_b_cnt, w_b_cnt;
    logic               r_a_to, w_a_to;
    logic               r_b_to, w_b_to;
    logic [NUM_REQ-1:0] r_lockout, w_lockout;
    logic [NUM_REQ-1:0] w_elig;
    logic               w_a_req, w_b_req;
    logic               w_a_hit, w_b_hit;
    code_t              w_first, w_second;
`ifdef ROUND_ROBIN_EN
    logic [3:0]         r_ptr, w_ptr;
`endif

    // Requests still eligible: not owned by either channel and not locked out
    always_comb begin
        w_elig  = req & ~code_to_onehot(r_a_id) & ~code_to_onehot(r_b_id) & ~r_lockout;
        w_a_req = |(req & code_to_onehot(r_a_id));
        w_b_req = |(req & code_to_onehot(r_b_id));
        w_a_hit = HOLD_EN && (r_a_cnt == HOLD_LAST);
        w_b_hit = HOLD_EN && (r_b_cnt == HOLD_LAST);
    end

    dual_pick_12 u_pick (
`ifdef ROUND_ROBIN_EN
        .i_ptr    (r_ptr),
`endif
        .i_vec    (w_elig),
        .o_first  (w_first),
        .o_second (w_second)
    );

    // Next-state for both channel FSMs, hold counters, timeouts and lockout
    always_comb begin
        w_a_state = r_a_state;
        w_a_id    = r_a_id;
        w_a_cnt   = r_a_cnt;
        w_a_to    = 1'b0;
        w_b_state = r_b_state;
        w_b_id    = r_b_id;
        w_b_cnt   = r_b_cnt;
        w_b_to    = 1'b0;
        w_lockout = r_lockout & req;

        case (r_a_state)
            IDLE: begin
                if (w_first != NO_GRANT) begin
                    w_a_state = BUSY;
                    w_a_id    = w_first;
                    w_a_cnt   = '0;
                end
            end
            BUSY: begin
                w_a_cnt = r_a_cnt + 1'b1;
                if (done_a || !w_a_req || w_a_hit) begin
                    w_a_state = IDLE;
                    w_a_id    = NO_GRANT;
                    w_a_cnt   = '0;
                    w_a_to    = w_a_hit && !done_a && w_a_req;
                end
            end
            default: w_a_state = IDLE;
        endcase

        case (r_b_state)
            IDLE: begin
                if (r_a_state == IDLE) begin
                    if (w_second != NO_GRANT) begin
                        w_b_state = BUSY;
                        w_b_id    = w_second;
                        w_b_cnt   = '0;
                    end
                end else if (w_first != NO_GRANT) begin
                    w_b_state = BUSY;
                    w_b_id    = w_first;
                    w_b_cnt   = '0;
                end
            end
            BUSY: begin
                w_b_cnt = r_b_cnt + 1'b1;
                if (done_b || !w_b_req || w_b_hit) begin
                    w_b_state = IDLE;
                    w_b_id    = NO_GRANT;
                    w_b_cnt   = '0;
                    w_b_to    = w_b_hit && !done_b && w_b_req;
                end
            end
            default: w_b_state = IDLE;
        endcase

        if (w_a_to) begin
            w_lockout = w_lockout | code_to_onehot(r_a_id);
        end
        if (w_b_to) begin
            w_lockout = w_lockout | code_to_onehot(r_b_id);
        end
    end

`ifdef ROUND_ROBIN_EN
    // Pointer follows the newest grant; B's grant wins when both grant together
    always_comb begin
        w_ptr = r_ptr;
        if (r_b_state == IDLE && w_b_state == BUSY) begin
            w_ptr = w_b_id - 4'd1;
        end else if (r_a_state == IDLE && w_a_state == BUSY) begin
            w_ptr = w_a_id - 4'd1;
        end
    end

    // Rotating priority pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr;
        end
    end
`endif

    // State register: reset drops any grant immediately without pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_state <= IDLE;
            r_b_state <= IDLE;
            r_a_id    <= NO_GRANT;
            r_b_id    <= NO_GRANT;
            r_a_cnt   <= '0;
            r_b_cnt   <= '0;
            r_a_to    <= 1'b0;
            r_b_to    <= 1'b0;
            r_lockout <= '0;
        end else begin
            r_a_state <= w_a_state;
            r_b_state <= w_b_state;
            r_a_id    <= w_a_id;
            r_b_id    <= w_b_id;
            r_a_cnt   <= w_a_cnt;
            r_b_cnt   <= w_b_cnt;
            r_a_to    <= w_a_to;
            r_b_to    <= w_b_to;
            r_lockout <= w_lockout;
        end
    end

    assign gnt_a_id    = r_a_id;
    assign gnt_b_id    = r_b_id;
    assign gnt_a_valid = (r_a_state == BUSY);
    assign gnt_b_valid = (r_b_state == BUSY);
    assign timeout_a   = r_a_to;
    assign timeout_b   = r_b_to;

endmodule

// File: tb/tb_dual_grant_arbiter.sv
// tb_dual_grant_arbiter: directed scenarios plus randomized traffic, checked
// every cycle against a behavioural model of the arbitration rules.
// Built with the default configuration (ROUND_ROBIN_EN undefined).
module tb_dual_grant_arbiter;

    localparam int TB_MAX_HOLD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] req;
    logic        done_a;
    logic        done_b;
    logic [3:0]  gnt_a_id;
    logic [3:0]  gnt_b_id;
    logic        gnt_a_valid;
    logic        gnt_b_valid;
    logic        timeout_a;
    logic        timeout_b;

    int checks = 0;
    int errors = 0;

    // Model state: owner index per channel (-1 = idle), cycles held so far
    int mOwner[2];
    int mHeld[2];
    bit mTo[2];
    bit mLocked[12];

    dual_grant_arbiter #(
        .MAX_HOLD (TB_MAX_HOLD),
        .HOLD_W   (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done_a      (done_a),
        .done_b      (done_b),
        .gnt_a_id    (gnt_a_id),
        .gnt_b_id    (gnt_b_id),
        .gnt_a_valid (gnt_a_valid),
        .gnt_b_valid (gnt_b_valid),
        .timeout_a   (timeout_a),
        .timeout_b   (timeout_b)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d at t=%0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int c = 0; c < 2; c++) begin
            mOwner[c] = -1;
            mHeld[c]  = 0;
            mTo[c]    = 1'b0;
        end
        for (int i = 0; i < 12; i++) begin
            mLocked[i] = 1'b0;
        end
    endtask

    // One clock edge of the arbitration rules, using the inputs seen at the edge
    task automatic modelStep(input logic [11:0] r, input logic da, input logic db);
        int nOwner[2];
        int nHeld[2];
        bit nTo[2];
        bit nLocked[12];
        bit dn[2];
        int picks[$];
        bit still;
        bit expired;
        dn[0] = da;
        dn[1] = db;
        for (int i = 0; i < 12; i++) begin
            nLocked[i] = mLocked[i] && r[i];
        end
        for (int i = 11; i >= 0; i--) begin
            if (r[i] && mOwner[0] != i && mOwner[1] != i && !mLocked[i]) begin
                picks.push_back(i);
            end
        end
        for (int c = 0; c < 2; c++) begin
            nOwner[c] = mOwner[c];
            nHeld[c]  = mHeld[c];
            nTo[c]    = 1'b0;
            if (mOwner[c] >= 0) begin
                still   = r[mOwner[c]];
                expired = (TB_MAX_HOLD > 0) && (mHeld[c] >= TB_MAX_HOLD);
                if (dn[c] || !still || expired) begin
                    nOwner[c] = -1;
                    nHeld[c]  = 0;
                    if (expired && !dn[c] && still) begin
                        nTo[c] = 1'b1;
                        nLocked[mOwner[c]] = 1'b1;
                    end
                end else begin
                    nHeld[c] = mHeld[c] + 1;
                end
            end
        end
        if (mOwner[0] < 0 && mOwner[1] < 0) begin
            if (picks.size() > 0) begin
                nOwner[0] = picks[0];
                nHeld[0]  = 1;
            end
            if (picks.size() > 1) begin
                nOwner[1] = picks[1];
                nHeld[1]  = 1;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (mOwner[c] < 0 && picks.size() > 0) begin
                    nOwner[c] = picks[0];
                    nHeld[c]  = 1;
                end
            end
        end
        for (int c = 0; c < 2; c++) begin
            mOwner[c] = nOwner[c];
            mHeld[c]  = nHeld[c];
            mTo[c]    = nTo[c];
        end
        for (int i = 0; i < 12; i++) begin
            mLocked[i] = nLocked[i];
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".a_id"}, 32'(gnt_a_id),
                    (mOwner[0] >= 0) ? 32'(mOwner[0] + 1) : 32'd0);
        checkOutput({tag, ".b_id"}, 32'(gnt_b_id),
                    (mOwner[1] >= 0) ? 32'(mOwner[1] + 1) : 32'd0);
        checkOutput({tag, ".a_valid"}, 32'(gnt_a_valid), 32'(mOwner[0] >= 0));
        checkOutput({tag, ".b_valid"}, 32'(gnt_b_valid), 32'(mOwner[1] >= 0));
        checkOutput({tag, ".a_to"}, 32'(timeout_a), 32'(mTo[0]));
        checkOutput({tag, ".b_to"}, 32'(timeout_b), 32'(mTo[1]));
    endtask

    // Drive one cycle of inputs, advance model at the edge, check just after it
    task automatic applyStimulus(input logic [11:0] r, input logic da,
                                 input logic db, input string tag);
        req    = r;
        done_a = da;
        done_b = db;
        @(posedge clk);
        if (!rst_n) begin
            modelReset();
        end else begin
            modelStep(r, da, db);
        end
        #1;
        checkAll(tag);
    endtask

    // Assert reset between edges and confirm outputs clear without a clock
    task automatic midCycleReset(input string tag);
        rst_n = 1'b0;
        #2;
        modelReset();
        checkAll(tag);
    endtask

    initial begin
        logic [11:0] rq;
        int          sel;
        logic        da;
        logic        db;

        rst_n  = 1'b0;
        req    = 12'hFFF;
        done_a = 1'b0;
        done_b = 1'b0;
        modelReset();

        // Reset with all requests active, then the top two win
        #1;
        checkAll("t1.rst");
        applyStimulus(12'hFFF, 1'b0, 1'b0, "t1.rst_edge");
        checkOutput("t1.rst_a_valid", 32'(gnt_a_valid), 32'd0);
        rst_n = 1'b1;
        applyStimulus(12'hFFF, 1'b0, 1'b0, "t1.grant");
        checkOutput("t1.a_id", 32'(gnt_a_id), 32'd12);
        checkOutput("t1.b_id", 32'(gnt_b_id), 32'd11);
        checkOutput("t1.both_valid", 32'({gnt_a_valid, gnt_b_valid}), 32'd3);
        applyStimulus(12'h000, 1'b0, 1'b0, "t1.drop");

        // Two requests from idle, then done_b gives one idle cycle on B
        applyStimulus(12'h0A0, 1'b0, 1'b0, "t2.grant");
        checkOutput("t2.a_id", 32'(gnt_a_id), 32'd8);
        checkOutput("t2.b_id", 32'(gnt_b_id), 32'd6);
        applyStimulus(12'h0A0, 1'b0, 1'b1, "t2.done_b");
        checkOutput("t2.b_idle", 32'(gnt_b_valid), 32'd0);
        checkOutput("t2.a_kept", 32'(gnt_a_id), 32'd8);
        applyStimulus(12'h0A0, 1'b0, 1'b0, "t2.regrant");
        checkOutput("t2.b_regrant", 32'(gnt_b_id), 32'd6);

        // Higher request arrives; done_a frees A, which then picks 12
        applyStimulus(12'h8A0, 1'b1, 1'b0, "t3.done_a");
        checkOutput("t3.a_idle", 32'(gnt_a_valid), 32'd0);
        checkOutput("t3.b_kept", 32'(gnt_b_id), 32'd6);
        applyStimulus(12'h8A0, 1'b0, 1'b0, "t3.regrant");
        checkOutput("t3.a_id", 32'(gnt_a_id), 32'd12);
        checkOutput("t3.b_still", 32'(gnt_b_id), 32'd6);
        applyStimulus(12'h000, 1'b0, 1'b0, "t3.drop");

        // Owner drops its request: release with no timeout
        applyStimulus(12'h010, 1'b0, 1'b0, "t4.grant");
        checkOutput("t4.a_id", 32'(gnt_a_id), 32'd5);
        applyStimulus(12'h000, 1'b0, 1'b0, "t4.drop");
        checkOutput("t4.a_valid", 32'(gnt_a_valid), 32'd0);
        checkOutput("t4.a_id0", 32'(gnt_a_id), 32'd0);
        checkOutput("t4.no_to", 32'(timeout_a), 32'd0);

        // Hold limit of 4 cycles, then lockout until the request toggles
        for (int i = 0; i < TB_MAX_HOLD; i++) begin
            applyStimulus(12'h001, 1'b0, 1'b0, "t5.hold");
            checkOutput("t5.a_id", 32'(gnt_a_id), 32'd1);
        end
        applyStimulus(12'h001, 1'b0, 1'b0, "t5.timeout");
        checkOutput("t5.to_pulse", 32'(timeout_a), 32'd1);
        checkOutput("t5.a_released", 32'(gnt_a_valid), 32'd0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(12'h001, 1'b0, 1'b0, "t5.locked");
            checkOutput("t5.lock_a_valid", 32'(gnt_a_valid), 32'd0);
            checkOutput("t5.to_single", 32'(timeout_a), 32'd0);
        end
        applyStimulus(12'h000, 1'b0, 1'b0, "t5.fall");
        applyStimulus(12'h001, 1'b0, 1'b0, "t5.rise");
        checkOutput("t5.regrant", 32'(gnt_a_id), 32'd1);
        applyStimulus(12'h000, 1'b0, 1'b0, "t5.idle");

        // Reset mid-grant, then simultaneous done on both channels
        applyStimulus(12'h0A0, 1'b0, 1'b0, "t6.grant");
        midCycleReset("t6.async");
        checkOutput("t6.a_cleared", 32'(gnt_a_id), 32'd0);
        checkOutput("t6.b_cleared", 32'(gnt_b_valid), 32'd0);
        applyStimulus(12'h0A0, 1'b0, 1'b0, "t6.in_reset");
        rst_n = 1'b1;
        applyStimulus(12'h0A0, 1'b0, 1'b0, "t6.regrant");
        checkOutput("t6.both_busy", 32'({gnt_a_valid, gnt_b_valid}), 32'd3);
        applyStimulus(12'h0A0, 1'b1, 1'b1, "t6.dual_done");
        checkOutput("t6.both_idle", 32'({gnt_a_valid, gnt_b_valid}), 32'd0);
        checkOutput("t6.no_to", 32'({timeout_a, timeout_b}), 32'd0);
        applyStimulus(12'h000, 1'b0, 1'b0, "t6.drop");

        // Randomized traffic: request churn, done pulses, occasional reset
        rq = 12'h000;
        for (int c = 0; c < 2500; c++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0) begin
                rq = 12'($urandom);
            end else if (sel <= 3) begin
                rq = rq ^ (12'd1 << $urandom_range(0, 11));
            end
            da = ($urandom_range(0, 5) == 0);
            db = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 299) == 0) begin
                midCycleReset("rnd.async");
                applyStimulus(rq, da, db, "rnd.in_reset");
                rst_n = 1'b1;
            end
            applyStimulus(rq, da, db, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dual_grant_arbiter.md
Name: dual_grant_arbiter

Overview:
Shares two identical downstream resources (channel A, channel B) among 12 requesters. It uses dual-priority selection: in one cycle it finds the highest and second-highest eligible requests. When both channels are free, A takes the first pick and B takes the second. Each grant is held until the owner reports done, drops its request, or exceeds a hold limit. It sits between the request sources and the shared resource pair, and reuses the 4-bit request code convention: code 0 means none, codes 1..12 map to req[0]..req[11].

Parameters:
NUM_REQ, 12, number of requesters; fixed at 12 for 4-bit codes.
MAX_HOLD, 255, maximum cycles a channel stays granted before forced release; 0 disables the limit.
HOLD_W, 8, hold counter width; must satisfy MAX_HOLD < 2**HOLD_W.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  12  level request; req[11] has highest fixed priority
done_a  in  1  single-cycle pulse: channel A owner has finished
done_b  in  1  single-cycle pulse: channel B owner has finished
gnt_a_id  out  4  channel A owner code; 0 when idle
gnt_b_id  out  4  channel B owner code; 0 when idle
gnt_a_valid  out  1  channel A is granted
gnt_b_valid  out  1  channel B is granted
timeout_a  out  1  single-cycle pulse: A was force-released
timeout_b  out  1  single-cycle pulse: B was force-released

Behaviour:
- Reset (asynchronous, while rst_n=0): all outputs 0, both channels IDLE, hold counters 0, lockout mask 0. Reset asserted mid-grant drops the grant immediately, with no done or timeout pulse.
- Each channel has a 2-state FSM: IDLE, BUSY. All outputs are registered.
- Eligible vector: req & ~owner_onehot(A) & ~owner_onehot(B) & ~lockout. A requester never owns both channels.
- Both channels IDLE: A <- first eligible, B <- second eligible. With only one eligible request, only A is granted.
- One channel IDLE: that channel <- first eligible.
- Latency: req rises in cycle N -> gnt_*_valid/id valid in cycle N+1.
- Release in BUSY happens on done_x, or when req[owner]=0, or when hold count reaches MAX_HOLD.
- Release effect: the channel is IDLE in the next cycle with id=0. A new grant on that channel comes no earlier than the cycle after that, giving one guaranteed idle cycle.
- done_x while IDLE is ignored.
- done_a and done_b in the same cycle: both channels are released independently.
- Hold counter: cleared on grant, incremented every BUSY cycle. When it reaches MAX_HOLD, timeout_x pulses for 1 cycle coincident with the release.
- Lockout: a timed-out requester's lockout bit is set until its req drops to 0, so it is not re-granted while still holding req.
- Precedence when several release causes coincide: timeout is reported (timeout_x=1) only if done_x=0 and req[owner]=1.

Optional Feature:
Macro ROUND_ROBIN_EN.
- Defined: a 4-bit rotating pointer is added. After each grant, the granted index becomes lowest priority, and priority descends cyclically from the index just below it. When both channels grant in one cycle, the pointer moves to B's grant.
- Undefined: fixed priority, req[11] highest, req[0] lowest; no pointer register.

Decomposition:
- Package dual_grant_pkg holds: NUM_REQ=12, CODE_W=4, code_t (logic [3:0]), NO_GRANT=4'd0, chan_state_t enum {IDLE, BUSY}, and functions code_to_onehot / onehot index to code.
- One sub-module, dual_pick_12: combinational; takes a 12-bit masked vector (and the rotation pointer under ROUND_ROBIN_EN) and returns first/second codes. It is instantiated once.

Test Plan (default build, fixed priority):
1. rst_n=0 with req=12'hFFF -> all outputs 0. Release reset -> next cycle gnt_a_id=12, gnt_b_id=11, both valid.
2. req=12'h0A0 from idle -> one cycle later gnt_a_id=8, gnt_b_id=6. Then done_b pulse -> B idle for 1 cycle, then B re-grants 6.
3. A owns 8, B owns 6; raise req[11]; pulse done_a -> A idle 1 cycle, then gnt_a_id=12. B stays 6 throughout.
4. A owns 5; drop req[4] with no done -> next cycle gnt_a_valid=0, gnt_a_id=0, timeout_a=0.
5. MAX_HOLD=4, req=12'h001 held, no done -> gnt_a_id=1 for 4 cycles, timeout_a pulses, A idle. A stays idle until req[0] falls and rises again, then A re-grants 1.
6. Reset mid-grant plus simultaneous done -> assert rst_n=0 while both are BUSY: outputs clear asynchronously. After reset, pulse done_a and done_b together while both are BUSY -> both channels IDLE next cycle.
